alu8_issuer: RTL and testbench

ALU8_ISSUER -- requirements
Module: alu8_issuer

---
 rtl/alu8_issuer.sv | 168 ++++++++++++++++
 tb/tb_alu8_issuer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu8_issuer.sv
// rtl/alu8_issuer.sv - command FIFO feeding an 8-bit ALU through an issue/wait/respond FSM
// Results are sampled WAIT_CYCLES after the enable pulse and held until the consumer accepts.
module alu8_issuer #(
    parameter int DEPTH       = 4,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [7:0]               cmd_opcode,
    input  logic [7:0]               cmd_lhs,
    input  logic [7:0]               cmd_rhs,
    output logic                     alu_enable,
    output logic [7:0]               alu_opcode,
    output logic [7:0]               alu_lhs,
    output logic [7:0]               alu_rhs,
    input  logic [7:0]               alu_result,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [7:0]               rsp_data,
    output logic [7:0]               rsp_opcode,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [WW-1:0]  wait_cnt_q, wait_cnt_d;
    logic [7:0]     op_opcode_q, op_opcode_d;
    logic [7:0]     op_lhs_q, op_lhs_d;
    logic [7:0]     op_rhs_q, op_rhs_d;
    logic [7:0]     rsp_data_q, rsp_data_d;
    logic [7:0]     rsp_opcode_q, rsp_opcode_d;
    logic           alu_enable_q, alu_enable_d;
    logic           rsp_valid_q, rsp_valid_d;

    logic [23:0]    mem_q [DEPTH];
    logic [23:0]    head;
    logic           push;
    logic           pop;

    assign cmd_ready = (count_q != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    assign pop       = (state_q == S_IDLE) && (count_q != '0);
    assign head      = mem_q[rd_ptr_q];

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        wait_cnt_d   = wait_cnt_q;
        op_opcode_d  = op_opcode_q;
        op_lhs_d     = op_lhs_q;
        op_rhs_d     = op_rhs_q;
        rsp_data_d   = rsp_data_q;
        rsp_opcode_d = rsp_opcode_q;

        // Pointers are AW bits wide, so increments wrap modulo DEPTH.
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    op_opcode_d = head[23:16];
                    op_lhs_d    = head[15:8];
                    op_rhs_d    = head[7:0];
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_cnt_d = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (wait_cnt_q == WW'(WAIT_CYCLES - 1)) begin
                    rsp_data_d   = alu_result;
                    rsp_opcode_d = op_opcode_q;
                    state_d      = S_RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q + WW'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Outputs are registered from the next state so they align with it.
        alu_enable_d = (state_d == S_ISSUE);
        rsp_valid_d  = (state_d == S_RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            count_q      <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            wait_cnt_q   <= '0;
            op_opcode_q  <= '0;
            op_lhs_q     <= '0;
            op_rhs_q     <= '0;
            rsp_data_q   <= '0;
            rsp_opcode_q <= '0;
            alu_enable_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            wait_cnt_q   <= wait_cnt_d;
            op_opcode_q  <= op_opcode_d;
            op_lhs_q     <= op_lhs_d;
            op_rhs_q     <= op_rhs_d;
            rsp_data_q   <= rsp_data_d;
            rsp_opcode_q <= rsp_opcode_d;
            alu_enable_q <= alu_enable_d;
            rsp_valid_q  <= rsp_valid_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define what is live.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem_q[wr_ptr_q] <= {cmd_opcode, cmd_lhs, cmd_rhs};
        end
    end

    assign alu_enable = alu_enable_q;
    assign alu_opcode = op_opcode_q;
    assign alu_lhs    = op_lhs_q;
    assign alu_rhs    = op_rhs_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_opcode = rsp_opcode_q;
    assign count      = count_q;
    assign busy       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_alu8_issuer.sv
// tb/tb_alu8_issuer.sv - directed and random checks of alu8_issuer against a queue-based model
module tb_alu8_issuer;

    localparam int DEPTH = 4;
    localparam int W     = 2;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_opcode;
    logic [7:0]    cmd_lhs;
    logic [7:0]    cmd_rhs;
    logic          alu_enable;
    logic [7:0]    alu_opcode;
    logic [7:0]    alu_lhs;
    logic [7:0]    alu_rhs;
    logic [7:0]    alu_result;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [7:0]    rsp_data;
    logic [7:0]    rsp_opcode;
    logic          busy;
    logic [CW-1:0] count;

    alu8_issuer #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opcode(cmd_opcode), .cmd_lhs(cmd_lhs), .cmd_rhs(cmd_rhs),
        .alu_enable(alu_enable), .alu_opcode(alu_opcode), .alu_lhs(alu_lhs), .alu_rhs(alu_rhs),
        .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_opcode(rsp_opcode),
        .busy(busy), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] alu_fn(input logic [7:0] op, input logic [7:0] l, input logic [7:0] r);
        case (op)
            8'h01:   return l - r;
            8'h02:   return l + r;
            8'h03:   return l & r;
            8'h04:   return l | r;
            8'h05:   return l ^ r;
            default: return op;
        endcase
    endfunction

    assign alu_result = alu_fn(alu_opcode, alu_lhs, alu_rhs);

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, the engine as a stage number
    // (0 idle, 1 issue, 2..W+1 waiting, W+2 holding a response).
    logic [23:0] fifo_m [$];
    logic [15:0] got_q [$];
    int          stage_m = 0;
    logic [23:0] cur_m   = '0;
    logic [7:0]  res_m   = '0;
    logic [7:0]  rop_m   = '0;
    int          en_cnt  = 0;
    int          rsp_cycles = 0;
    logic        push_ok;

    always @(negedge clk) begin
        check("count", 32'(count), 32'(fifo_m.size()));
        check("cmd_ready", 32'(cmd_ready), 32'(fifo_m.size() != DEPTH));
        check("alu_enable", 32'(alu_enable), 32'(stage_m == 1));
        check("rsp_valid", 32'(rsp_valid), 32'(stage_m == W + 2));
        check("busy", 32'(busy), 32'(fifo_m.size() != 0 || stage_m != 0));
        check("alu_operands", {8'h0, alu_opcode, alu_lhs, alu_rhs}, {8'h0, cur_m});
        check("rsp_fields", {16'h0, rsp_opcode, rsp_data}, {16'h0, rop_m, res_m});
        if (alu_enable === 1'b1) en_cnt++;
        if (rsp_valid === 1'b1) rsp_cycles++;

        if (reset) begin
            fifo_m.delete();
            stage_m = 0;
            cur_m   = '0;
            res_m   = '0;
            rop_m   = '0;
        end else begin
            if (rsp_valid && rsp_ready) got_q.push_back({rsp_opcode, rsp_data});
            push_ok = cmd_valid && (fifo_m.size() < DEPTH);
            if (stage_m == 0) begin
                if (fifo_m.size() > 0) begin
                    cur_m   = fifo_m.pop_front();
                    stage_m = 1;
                end
            end else if (stage_m <= W) begin
                stage_m++;
            end else if (stage_m == W + 1) begin
                res_m = alu_fn(cur_m[23:16], cur_m[15:8], cur_m[7:0]);
                rop_m = cur_m[23:16];
                stage_m++;
            end else if (rsp_ready) begin
                stage_m = 0;
            end
            if (push_ok) fifo_m.push_back({cmd_opcode, cmd_lhs, cmd_rhs});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(busy), 32'(0));
    endtask

    task automatic run_one(input logic [7:0] op, input logic [7:0] l, input logic [7:0] r,
                           output logic [7:0] d, output logic [7:0] o);
        int n;
        cmd_valid = 1'b1; cmd_opcode = op; cmd_lhs = l; cmd_rhs = r;
        step();
        cmd_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("run_one_timeout", 32'(rsp_valid), 32'(1));
        d = rsp_data;
        o = rsp_opcode;
        step();
    endtask

    logic [7:0] d, o, d0;
    logic [7:0] b_op [6];
    logic [7:0] b_l  [6];
    logic [7:0] b_r  [6];
    int         e0, r0, idx, cyc;
    logic       saw_full, reopen;

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
        cmd_opcode = '0; cmd_lhs = '0; cmd_rhs = '0;
        step();
        cmd_valid = 1'b1;
        step();
        reset = 1'b0; cmd_valid = 1'b0;
        check("rst_count", 32'(count), 32'(0));
        check("rst_cmd_ready", 32'(cmd_ready), 32'(1));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));

        // Single add: latency and a single enable pulse.
        rsp_ready = 1'b1;
        e0 = en_cnt;
        cmd_valid = 1'b1; cmd_opcode = 8'h02; cmd_lhs = 8'h05; cmd_rhs = 8'h03;
        step();
        cmd_valid = 1'b0;
        repeat (3) step();
        check("lat_early", 32'(rsp_valid), 32'(0));
        step();
        check("lat_valid", 32'(rsp_valid), 32'(1));
        check("add_data", 32'(rsp_data), 32'h08);
        check("add_opcode", 32'(rsp_opcode), 32'h02);
        check("one_pulse", 32'(en_cnt - e0), 32'(1));
        step();
        check("lat_consumed", 32'(rsp_valid), 32'(0));

        run_one(8'h02, 8'hFF, 8'h01, d, o);
        check("wrap_data", 32'(d), 32'h00);
        run_one(8'h07, 8'h12, 8'h34, d, o);
        check("default_data", 32'(d), 32'h07);
        check("default_opcode", 32'(o), 32'h07);

        // Six back-to-back commands.
        for (int i = 0; i < 6; i++) begin
            b_op[i] = 8'($urandom_range(0, 7));
            b_l[i]  = 8'($urandom);
            b_r[i]  = 8'($urandom);
        end
        got_q.delete();
        saw_full = 1'b0; reopen = 1'b0; idx = 0; cyc = 0;
        while (idx < 6 && cyc < 100) begin
            cmd_valid = 1'b1;
            cmd_opcode = b_op[idx]; cmd_lhs = b_l[idx]; cmd_rhs = b_r[idx];
            if (cmd_ready === 1'b0 && count == CW'(DEPTH)) saw_full = 1'b1;
            if (saw_full && cmd_ready === 1'b1) reopen = 1'b1;
            if (cmd_ready === 1'b1) begin
                step();
                idx++;
            end else begin
                step();
            end
            cyc++;
        end
        cmd_valid = 1'b0;
        wait_idle("b2b_drain", 200);
        check("b2b_accepted", 32'(idx), 32'(6));
        check("b2b_saw_full", 32'(saw_full), 32'(1));
        check("b2b_reopen", 32'(reopen), 32'(1));
        check("b2b_rsp_count", 32'(got_q.size()), 32'(6));
        for (int i = 0; i < 6; i++) begin
            if (i < got_q.size())
                check("b2b_order", 32'(got_q[i]), 32'({b_op[i], alu_fn(b_op[i], b_l[i], b_r[i])}));
        end

        // Backpressure in RESP while the queue keeps filling.
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_opcode = 8'h03; cmd_lhs = 8'hF0; cmd_rhs = 8'h3C;
        step();
        cmd_valid = 1'b0;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 20) begin
            step();
            cyc++;
        end
        check("bp_rsp_valid", 32'(rsp_valid), 32'(1));
        check("bp_rsp_data", 32'(rsp_data), 32'h30);
        d0 = rsp_data;
        e0 = en_cnt;
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1;
            cmd_opcode = 8'($urandom_range(0, 7)); cmd_lhs = 8'($urandom); cmd_rhs = 8'($urandom);
            step();
            check("bp_hold_valid", 32'(rsp_valid), 32'(1));
            check("bp_hold_data", 32'(rsp_data), 32'(d0));
            check("bp_no_enable", 32'(alu_enable), 32'(0));
        end
        cmd_valid = 1'b0;
        check("bp_filled", 32'(count), 32'(DEPTH));
        check("bp_no_pulses", 32'(en_cnt - e0), 32'(0));
        rsp_ready = 1'b1;
        wait_idle("bp_drain", 200);

        // Reset in the second WAIT cycle with two entries queued.
        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            cmd_valid = 1'b1;
            cmd_opcode = 8'h02; cmd_lhs = 8'(i + 1); cmd_rhs = 8'h10;
            step();
        end
        cmd_valid = 1'b0;
        check("mid_queued", 32'(count), 32'(2));
        step();
        reset = 1'b1;
        cmd_valid = 1'b1; cmd_opcode = 8'h04; cmd_lhs = 8'hAA; cmd_rhs = 8'h55;
        step();
        reset = 1'b0;
        cmd_valid = 1'b0;
        check("mid_rst_count", 32'(count), 32'(0));
        check("mid_rst_enable", 32'(alu_enable), 32'(0));
        check("mid_rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("mid_rst_ready", 32'(cmd_ready), 32'(1));
        check("mid_rst_busy", 32'(busy), 32'(0));
        r0 = rsp_cycles;
        repeat (30) step();
        check("mid_no_response", 32'(rsp_cycles - r0), 32'(0));
        check("mid_no_handshake", 32'(got_q.size()), 32'(0));

        // Random traffic with occasional reset and backpressure.
        for (int i = 0; i < 3000; i++) begin
            cmd_valid  = 1'($urandom_range(0, 1));
            cmd_opcode = 8'($urandom_range(0, 7));
            cmd_lhs    = 8'($urandom);
            cmd_rhs    = 8'($urandom);
            rsp_ready  = ($urandom_range(0, 3) != 0);
            reset      = ($urandom_range(0, 299) == 0);
            step();
        end
        reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b1;
        wait_idle("final_drain", 200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
